// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receive path.
//   - ps2_state_e : frame sequencer states (IDLE, DATA, PARITY, STOP)
//   - PFX_* : prefix bytes that qualify the following scan code
//   - KEY_* : extended scan codes of the four arrow keys
//   - oddParityOk : true when data bits plus parity bit hold an odd
//                   number of ones
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    function automatic logic oddParityOk(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Brings the asynchronous PS/2 clock and data lines into the system clock
// domain and flags falling edges of the synchronized PS/2 clock.
//
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset (flops go to the idle bus level 1)
//   ps2Clk_i  raw PS/2 clock
//   ps2Dat_i  raw PS/2 data
//   datS_o    synchronized PS/2 data
//   fall_o    one-cycle pulse: synchronized PS/2 clock went 1 -> 0
//
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2Clk_i,
    input  logic ps2Dat_i,
    output logic datS_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] datSync_q;
    logic                   clkPrev_q;

    // Both lines travel through identical chains so data stays aligned with
    // the clock edge it belongs to. The extra clkPrev flop remembers the last
    // synchronized clock level for edge detection. Reset loads 1 everywhere
    // so that releasing reset on an idle bus never looks like an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkSync_q <= '1;
            datSync_q <= '1;
            clkPrev_q <= 1'b1;
        end else begin
            clkSync_q <= {clkSync_q[SYNC_STAGES-2:0], ps2Clk_i};
            datSync_q <= {datSync_q[SYNC_STAGES-2:0], ps2Dat_i};
            clkPrev_q <= clkSync_q[SYNC_STAGES-1];
        end
    end

    assign datS_o = datSync_q[SYNC_STAGES-1];
    assign fall_o = clkPrev_q & ~clkSync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl
// PS/2 keyboard receive sequencer. Frames 11-bit packets (start, 8 data bits
// LSB first, parity, stop) sampled on falling edges of the synchronized PS/2
// clock, tracks E0/F0 prefixes and reports decoded scan-code events plus
// held arrow-key direction levels.
//
// Parameters:
//   TIMEOUT_CYC  system-clock cycles without a PS/2 falling edge before an
//                in-progress frame is aborted
//   SYNC_STAGES  synchronizer depth on both PS/2 lines (min 2)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ps2_clk     raw PS/2 clock
//   ps2_dat     raw PS/2 data
//   scan_code   last non-prefix byte received
//   scan_valid  one-cycle pulse, scan_code/ext/brk updated
//   ext         E0 prefix preceded scan_code
//   brk         F0 prefix preceded scan_code (key release)
//   dir_left    held level, extended 6B pressed
//   dir_right   held level, extended 74 pressed
//   dir_up      held level, extended 75 pressed
//   dir_down    held level, extended 72 pressed
//   frame_err   one-cycle pulse on an aborted or malformed frame
//
// Build option:
//   PS2_PARITY_CHK_EN  when defined, frames with even parity are discarded
//                      and flagged on frame_err; otherwise the parity bit
//                      is sampled and ignored.
// ---------------------------------------------------------------------------
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       ext,
    output logic       brk,
    output logic       dir_left,
    output logic       dir_right,
    output logic       dir_up,
    output logic       dir_down,
    output logic       frame_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic datS;
    logic fall;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ps2Clk_i(ps2_clk),
        .ps2Dat_i(ps2_dat),
        .datS_o  (datS),
        .fall_o  (fall)
    );

    ps2_state_e       state_q;
    logic [2:0]       bitCnt_q;
    logic [7:0]       shift_q;
    logic [CNT_W-1:0] toCnt_q;
    logic             extPend_q;
    logic             brkPend_q;
    logic [7:0]       scanCode_q;
    logic             scanValid_q;
    logic             ext_q;
    logic             brk_q;
    logic             dirLeft_q;
    logic             dirRight_q;
    logic             dirUp_q;
    logic             dirDown_q;
    logic             frameErr_q;
`ifdef PS2_PARITY_CHK_EN
    logic             parity_q;
`endif

    logic [7:0] shift_d;
    logic       timeout_d;
    logic       frameBad_d;

    // Helper values for the sequencer: the byte after shifting in the current
    // data sample (LSB arrives first, so new bits enter at bit 7), the
    // inter-edge timeout condition, and whether the frame ending at this
    // stop-bit sample must be rejected.
    always_comb begin
        shift_d   = {datS, shift_q[7:1]};
        timeout_d = (toCnt_q == CNT_LAST);
`ifdef PS2_PARITY_CHK_EN
        frameBad_d = !datS || !oddParityOk(shift_q, parity_q);
`else
        frameBad_d = !datS;
`endif
    end

    // Frame sequencer with all decoded outputs registered in the same block.
    // Pulses default low each cycle. Inside a frame every falling edge
    // restarts the timeout counter; if the counter reaches its last value
    // before the next edge arrives, the frame is dropped as an error.
    // A bad frame (stop bit low, timeout, parity when enabled) discards any
    // pending E0/F0 so a later key is not misreported as extended/released;
    // direction levels are deliberately left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            toCnt_q     <= '0;
            extPend_q   <= 1'b0;
            brkPend_q   <= 1'b0;
            scanCode_q  <= '0;
            scanValid_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            dirLeft_q   <= 1'b0;
            dirRight_q  <= 1'b0;
            dirUp_q     <= 1'b0;
            dirDown_q   <= 1'b0;
            frameErr_q  <= 1'b0;
`ifdef PS2_PARITY_CHK_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            scanValid_q <= 1'b0;
            frameErr_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    toCnt_q <= '0;
                    // A falling edge with data high is bus noise, not a start bit.
                    if (fall && !datS) begin
                        state_q  <= DATA;
                        bitCnt_q <= '0;
                    end
                end

                default: begin
                    if (fall) begin
                        toCnt_q <= '0;
                        case (state_q)
                            DATA: begin
                                shift_q  <= shift_d;
                                bitCnt_q <= bitCnt_q + 3'd1;
                                if (bitCnt_q == 3'd7) begin
                                    state_q <= PARITY;
                                end
                            end

                            PARITY: begin
`ifdef PS2_PARITY_CHK_EN
                                parity_q <= datS;
`endif
                                state_q  <= STOP;
                            end

                            STOP: begin
                                state_q <= IDLE;
                                if (frameBad_d) begin
                                    frameErr_q <= 1'b1;
                                    extPend_q  <= 1'b0;
                                    brkPend_q  <= 1'b0;
                                end else if (shift_q == PFX_EXT) begin
                                    extPend_q <= 1'b1;
                                end else if (shift_q == PFX_BRK) begin
                                    brkPend_q <= 1'b1;
                                end else begin
                                    scanCode_q  <= shift_q;
                                    ext_q       <= extPend_q;
                                    brk_q       <= brkPend_q;
                                    scanValid_q <= 1'b1;
                                    extPend_q   <= 1'b0;
                                    brkPend_q   <= 1'b0;
                                    // Only extended arrow codes steer; a
                                    // release (F0) drops the level again.
                                    if (extPend_q) begin
                                        case (shift_q)
                                            KEY_LEFT:  dirLeft_q  <= ~brkPend_q;
                                            KEY_RIGHT: dirRight_q <= ~brkPend_q;
                                            KEY_UP:    dirUp_q    <= ~brkPend_q;
                                            KEY_DOWN:  dirDown_q  <= ~brkPend_q;
                                            default:   ;
                                        endcase
                                    end
                                end
                            end

                            default: state_q <= IDLE;
                        endcase
                    end else if (timeout_d) begin
                        state_q    <= IDLE;
                        toCnt_q    <= '0;
                        frameErr_q <= 1'b1;
                        extPend_q  <= 1'b0;
                        brkPend_q  <= 1'b0;
                    end else begin
                        toCnt_q <= toCnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign scan_code  = scanCode_q;
    assign scan_valid = scanValid_q;
    assign ext        = ext_q;
    assign brk        = brk_q;
    assign dir_left   = dirLeft_q;
    assign dir_right  = dirRight_q;
    assign dir_up     = dirUp_q;
    assign dir_down   = dirDown_q;
    assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_ctrl
// Drives PS/2 frames into ps2_key_ctrl. A key-event model kept here predicts
// which frames produce scan events or frame errors and what the held
// outputs must be; a compare process checks the DUT every cycle, and
// literal checks after each scenario pin the model to known values.
// ---------------------------------------------------------------------------
module tb_ps2_key_ctrl;

    localparam int TO_CYC = 300;
    localparam int HALF   = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2Clk;
    logic       ps2Dat;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       ext;
    logic       brk;
    logic       dir_left;
    logic       dir_right;
    logic       dir_up;
    logic       dir_down;
    logic       frame_err;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } keyEvent_t;

    keyEvent_t  expQ[$];
    int         errPending;
    logic       pendExt;
    logic       pendBrk;
    logic [7:0] mCode;
    logic       mExt;
    logic       mBrk;
    logic       mLeft;
    logic       mRight;
    logic       mUp;
    logic       mDown;
    int         checks = 0;
    int         errors = 0;

    ps2_key_ctrl #(
        .TIMEOUT_CYC(TO_CYC),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2Clk),
        .ps2_dat   (ps2Dat),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .ext       (ext),
        .brk       (brk),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .frame_err (frame_err)
    );

    // 100 MHz-style system clock; the PS/2 bit period is far slower.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        expQ.delete();
        errPending = 0;
        pendExt    = 1'b0;
        pendBrk    = 1'b0;
        mCode      = 8'h00;
        mExt       = 1'b0;
        mBrk       = 1'b0;
        mLeft      = 1'b0;
        mRight     = 1'b0;
        mUp        = 1'b0;
        mDown      = 1'b0;
    endtask

    // One PS/2 bit: device sets data while the clock is high, host samples
    // on the falling edge.
    task automatic sendBit(input logic b);
        ps2Dat = b;
        waitCycles(HALF);
        ps2Clk = 1'b0;
        waitCycles(HALF);
        ps2Clk = 1'b1;
    endtask

    // Sends a complete frame and records its expected outcome in the model.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parFlip);
        logic        par;
        logic        bad;
        logic [10:0] frame;
        par = ~(^data) ^ parFlip;
        bad = ~stopBit;
`ifdef PS2_PARITY_CHK_EN
        bad = bad | parFlip;
`endif
        if (bad) begin
            errPending++;
            pendExt = 1'b0;
            pendBrk = 1'b0;
        end else if (data == 8'hE0) begin
            pendExt = 1'b1;
        end else if (data == 8'hF0) begin
            pendBrk = 1'b1;
        end else begin
            expQ.push_back('{data, pendExt, pendBrk});
            pendExt = 1'b0;
            pendBrk = 1'b0;
        end
        frame = {stopBit, par, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            sendBit(frame[i]);
        end
        ps2Dat = 1'b1;
        waitCycles(HALF);
    endtask

    // Start bit plus the first nBits data bits, then the line goes quiet.
    task automatic applyPartial(input logic [7:0] data, input int nBits);
        sendBit(1'b0);
        for (int i = 0; i < nBits; i++) begin
            sendBit(data[i]);
        end
        ps2Dat = 1'b1;
    endtask

    task automatic checkDrained(input string name);
        waitCycles(10);
        checks++;
        if (expQ.size() != 0 || errPending != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d key events and %0d frame errors outstanding, expected 0",
                     name, expQ.size(), errPending);
        end
    endtask

    // Per-cycle comparison against the key-event model. Every scan_valid must
    // match the oldest predicted event, every frame_err a predicted error;
    // the held outputs must equal the model's latest event and arrow levels.
    always @(negedge clk) begin : compare
        keyEvent_t e;
        if (scan_valid === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL scan_valid: got 1, expected 0 (no key event due)");
            end else begin
                e     = expQ.pop_front();
                mCode = e.code;
                mExt  = e.ext;
                mBrk  = e.brk;
                if (e.ext) begin
                    if (e.code == 8'h6B) mLeft  = ~e.brk;
                    if (e.code == 8'h74) mRight = ~e.brk;
                    if (e.code == 8'h75) mUp    = ~e.brk;
                    if (e.code == 8'h72) mDown  = ~e.brk;
                end
            end
        end
        if (frame_err === 1'b1) begin
            checks++;
            if (errPending == 0) begin
                errors++;
                $display("[TB] FAIL frame_err: got 1, expected 0 (no error due)");
            end else begin
                errPending--;
            end
        end
        checkOutput("scan_code", scan_code, mCode);
        checkBit("ext", ext, mExt);
        checkBit("brk", brk, mBrk);
        checkBit("dir_left", dir_left, mLeft);
        checkBit("dir_right", dir_right, mRight);
        checkBit("dir_up", dir_up, mUp);
        checkBit("dir_down", dir_down, mDown);
    end

    initial begin
        rst_n  = 1'b0;
        ps2Clk = 1'b1;
        ps2Dat = 1'b1;
        modelReset();
        waitCycles(4);
        checkBit("rst_scan_valid", scan_valid, 1'b0);
        checkBit("rst_frame_err", frame_err, 1'b0);
        checkOutput("rst_scan_code", scan_code, 8'h00);
        checkBit("rst_dir_left", dir_left, 1'b0);
        rst_n = 1'b1;
        waitCycles(4);

        // Plain make code 1C.
        applyStimulus(8'h1C, 1'b1, 1'b0);
        checkDrained("t1_drain");
        checkOutput("t1_code", scan_code, 8'h1C);
        checkBit("t1_ext", ext, 1'b0);
        checkBit("t1_brk", brk, 1'b0);
        checkBit("t1_left", dir_left, 1'b0);

        // Extended left press, then release.
        applyStimulus(8'hE0, 1'b1, 1'b0);
        applyStimulus(8'h6B, 1'b1, 1'b0);
        checkDrained("t2_press_drain");
        checkBit("t2_press_ext", ext, 1'b1);
        checkBit("t2_press_left", dir_left, 1'b1);
        checkBit("t2_press_brk", brk, 1'b0);
        applyStimulus(8'hE0, 1'b1, 1'b0);
        applyStimulus(8'hF0, 1'b1, 1'b0);
        applyStimulus(8'h6B, 1'b1, 1'b0);
        checkDrained("t2_rel_drain");
        checkBit("t2_rel_brk", brk, 1'b1);
        checkBit("t2_rel_ext", ext, 1'b1);
        checkBit("t2_rel_left", dir_left, 1'b0);
        checkOutput("t2_rel_code", scan_code, 8'h6B);

        // Up and right held together, then reset in the middle of a frame.
        applyStimulus(8'hE0, 1'b1, 1'b0);
        applyStimulus(8'h75, 1'b1, 1'b0);
        applyStimulus(8'hE0, 1'b1, 1'b0);
        applyStimulus(8'h74, 1'b1, 1'b0);
        checkDrained("t3_drain");
        checkBit("t3_up", dir_up, 1'b1);
        checkBit("t3_right", dir_right, 1'b1);
        checkBit("t3_left", dir_left, 1'b0);
        applyPartial(8'h1C, 3);
        rst_n = 1'b0;
        #1;
        checkOutput("t3_rst_code", scan_code, 8'h00);
        checkBit("t3_rst_up", dir_up, 1'b0);
        checkBit("t3_rst_right", dir_right, 1'b0);
        checkBit("t3_rst_ext", ext, 1'b0);
        modelReset();
        ps2Clk = 1'b1;
        ps2Dat = 1'b1;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(3);
        applyStimulus(8'h1C, 1'b1, 1'b0);
        checkDrained("t3_fresh_drain");
        checkOutput("t3_fresh_code", scan_code, 8'h1C);
        checkBit("t3_fresh_ext", ext, 1'b0);

        // Pending E0, then a frame that stalls until the timeout fires.
        applyStimulus(8'hE0, 1'b1, 1'b0);
        errPending++;
        pendExt = 1'b0;
        pendBrk = 1'b0;
        applyPartial(8'h72, 4);
        waitCycles(TO_CYC + 20);
        checkDrained("t4_timeout_drain");
        applyStimulus(8'h72, 1'b1, 1'b0);
        checkDrained("t4_after_drain");
        checkOutput("t4_code", scan_code, 8'h72);
        checkBit("t4_ext", ext, 1'b0);
        checkBit("t4_down", dir_down, 1'b0);

        // Bad stop bit after a pending E0; the pend must not survive.
        applyStimulus(8'hE0, 1'b1, 1'b0);
        applyStimulus(8'h29, 1'b0, 1'b0);
        checkDrained("t5_stop_drain");
        checkOutput("t5_stop_code", scan_code, 8'h72);
        applyStimulus(8'h6B, 1'b1, 1'b0);
        checkDrained("t5_next_drain");
        checkBit("t5_next_ext", ext, 1'b0);
        checkBit("t5_next_left", dir_left, 1'b0);
        applyStimulus(8'h29, 1'b1, 1'b1);
        checkDrained("t5_par_drain");
`ifdef PS2_PARITY_CHK_EN
        checkOutput("t5_par_code", scan_code, 8'h6B);
`else
        checkOutput("t5_par_code", scan_code, 8'h29);
`endif

        // Clock glitch with data high while idle, then a break code.
        ps2Dat = 1'b1;
        ps2Clk = 1'b0;
        waitCycles(HALF);
        ps2Clk = 1'b1;
        waitCycles(HALF);
        applyStimulus(8'hF0, 1'b1, 1'b0);
        applyStimulus(8'h1C, 1'b1, 1'b0);
        checkDrained("t6_drain");
        checkOutput("t6_code", scan_code, 8'h1C);
        checkBit("t6_brk", brk, 1'b1);
        checkBit("t6_ext", ext, 1'b0);

        waitCycles(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
